// File: rtl/fht_result_reader_if.sv
// Output sample stream of fht_result_reader.
// A beat transfers on any clock edge where oVALID && iREADY. While oVALID is high and
// iREADY low, the master holds oDATA/oLAST stable. oVALID never waits on iREADY.
interface fht_result_reader_if #(
    parameter int D_BIT = 16
);
    logic [2*D_BIT-1:0] oDATA;
    logic               oVALID;
    logic               oLAST;
    logic               iREADY;

    modport master (output oDATA, output oVALID, output oLAST, input iREADY);
    modport slave  (input oDATA, input oVALID, input oLAST, output iREADY);
endinterface

// File: rtl/fht_result_reader.sv
// Unloads fht_top's four result banks in loader order and streams them through a credit FIFO.
// Optional FHT_RD_SQR_EN inserts a registered x*x power stage ahead of the FIFO.
module fht_result_reader #(
    parameter int D_BIT  = 16,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iRDY,
    output logic [A_BIT-1:0]   oADDR_RD,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    fht_result_reader_if.master stream,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [1:0]         oSTATE
);
    localparam int N_BIT = A_BIT + 2;
    localparam int DEPTH = RD_LAT + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t             state_q;
    logic [N_BIT-1:0]   n_q;
    logic               irdy_q;
    logic               done_q;

    logic [RD_LAT-1:0]  vld_pipe_q;
    logic [RD_LAT-1:0]  last_pipe_q;
    logic [1:0]         sel_pipe_q [RD_LAT];

    logic [2*D_BIT-1:0] fifo_data_q [DEPTH];
    logic               fifo_last_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [CNT_W-1:0]   inflight;
    logic [CNT_W:0]     used;
    logic               issue;
    logic [D_BIT-1:0]   cap_word;
    logic [2*D_BIT-1:0] cap_ext;
    logic               push, pop, push_last;
    logic [2*D_BIT-1:0] push_data;

`ifdef FHT_RD_SQR_EN
    logic [2*D_BIT-1:0] sq_q;
    logic               sq_vld_q, sq_last_q;
`endif

    // Reads issued but not yet landed in the FIFO still consume a slot.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[k]);
        end
`ifdef FHT_RD_SQR_EN
        inflight = inflight + CNT_W'(sq_vld_q);
`endif
    end

    assign used  = {1'b0, cnt_q} + {1'b0, inflight};
    assign issue = (state_q == S_READ) && (used < (CNT_W+1)'(DEPTH));

    always_comb begin
        cap_word = iDATA_0;
        case (sel_pipe_q[RD_LAT-1])
            2'd0:    cap_word = iDATA_0;
            2'd1:    cap_word = iDATA_1;
            2'd2:    cap_word = iDATA_2;
            default: cap_word = iDATA_3;
        endcase
    end

    assign cap_ext = {{D_BIT{cap_word[D_BIT-1]}}, cap_word};

`ifdef FHT_RD_SQR_EN
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            sq_vld_q  <= 1'b0;
            sq_last_q <= 1'b0;
            sq_q      <= '0;
        end else begin
            sq_vld_q  <= vld_pipe_q[RD_LAT-1];
            sq_last_q <= last_pipe_q[RD_LAT-1];
            sq_q      <= cap_ext * cap_ext;
        end
    end
    assign push      = sq_vld_q;
    assign push_data = sq_q;
    assign push_last = sq_last_q;
`else
    assign push      = vld_pipe_q[RD_LAT-1];
    assign push_data = cap_ext;
    assign push_last = last_pipe_q[RD_LAT-1];
`endif

    assign pop = (cnt_q != '0) && stream.iREADY;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bank select is the bit-reversed upper index, matching the loader's write order.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= issue;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
            end
        end
        sel_pipe_q[0]  <= {n_q[A_BIT], n_q[A_BIT+1]};
        last_pipe_q[0] <= (n_q == {N_BIT{1'b1}});
        for (int k = 1; k < RD_LAT; k++) begin
            sel_pipe_q[k]  <= sel_pipe_q[k-1];
            last_pipe_q[k] <= last_pipe_q[k-1];
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_last_q[wr_ptr_q] <= push_last;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            irdy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            irdy_q <= iRDY;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iRDY && !irdy_q) begin
                        state_q <= S_READ;
                        n_q     <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        n_q <= n_q + N_BIT'(1);
                        if (n_q == {N_BIT{1'b1}}) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0 && inflight == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oADDR_RD      = n_q[A_BIT-1:0];
    assign oBUSY         = (state_q != S_IDLE);
    assign oDONE         = done_q;
    assign oSTATE        = state_q;
    assign stream.oVALID = (cnt_q != '0);
    assign stream.oDATA  = stream.oVALID ? fifo_data_q[rd_ptr_q] : '0;
    assign stream.oLAST  = stream.oVALID ? fifo_last_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_fht_result_reader.sv
// Bench for fht_result_reader: RAM bank model, random data/backpressure, queue-based expected stream.
`timescale 1ns/1ps
module tb_fht_result_reader;
    localparam int D_BIT = 16;
    localparam int A_BIT = 8;
    localparam int RD_LAT = 2;
    localparam int BANK = 1 << A_BIT;
    localparam int N = 4 * BANK;
    localparam int W = 2 * D_BIT + 1;
`ifdef FHT_RD_SQR_EN
    localparam int SQ = 1;
`else
    localparam int SQ = 0;
`endif
    localparam int FIRST_LAT = 1 + RD_LAT + 1 + SQ;
    localparam int BUDGET = 20000;

    // ---------------- clock / reset / signals ----------------
    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    logic iRDY = 1'b0;
    logic [A_BIT-1:0] oADDR_RD;
    logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
    logic oBUSY, oDONE;
    logic [1:0] oSTATE;

    fht_result_reader_if #(.D_BIT(D_BIT)) st ();

    fht_result_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iRDY(iRDY), .oADDR_RD(oADDR_RD),
        .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
        .stream(st.master), .oBUSY(oBUSY), .oDONE(oDONE), .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    // ---------------- result RAM model (RD_LAT cycle read) ----------------
    logic [D_BIT-1:0] mem [4][BANK];
    logic [D_BIT-1:0] rd_pipe [RD_LAT][4];

    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            rd_pipe[0][b] <= mem[b][oADDR_RD];
            for (int k = 1; k < RD_LAT; k++) rd_pipe[k][b] <= rd_pipe[k-1][b];
        end
    end
    assign iDATA_0 = rd_pipe[RD_LAT-1][0];
    assign iDATA_1 = rd_pipe[RD_LAT-1][1];
    assign iDATA_2 = rd_pipe[RD_LAT-1][2];
    assign iDATA_3 = rd_pipe[RD_LAT-1][3];

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    int frame_beats = 0;
    int done_cnt = 0;
    int ready_pct = 100;
    logic [W-1:0] exp_q[$];
    logic stall_prev = 1'b0;
    logic [W-1:0] prev_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*D_BIT-1:0] model_word(input logic [D_BIT-1:0] x);
        int v;
        v = int'($signed(x));
`ifdef FHT_RD_SQR_EN
        return (2*D_BIT)'(v * v);
`else
        return (2*D_BIT)'(v);
`endif
    endfunction

    function automatic int rev2(input int i);
        return ((i & 1) << 1) | ((i >> 1) & 1);
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < BANK; j++)
                mem[rev2(i)][j] = D_BIT'(i * BANK + j);
    endtask

    task automatic fill_random();
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < BANK; j++)
                mem[b][j] = D_BIT'($urandom);
    endtask

    // Expected stream: sample n lives in bank rev(n / BANK) at address n % BANK.
    task automatic load_expected();
        exp_q.delete();
        for (int n = 0; n < N; n++) begin
            logic [D_BIT-1:0] x;
            x = mem[rev2(n / BANK)][n % BANK];
            exp_q.push_back({(n == N - 1), model_word(x)});
        end
    endtask

    initial begin
        st.iREADY = 1'b1;
        forever begin
            @(posedge iCLK);
            #1 st.iREADY = ($urandom_range(99) < ready_pct);
        end
    end

    // Single compare process: every accepted beat against the expected queue, plus hold-while-stalled.
    always @(negedge iCLK) begin
        if (!iRESET) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(st.oVALID), 64'd1);
                check("hold_data", 64'({st.oLAST, st.oDATA}), 64'(prev_out));
            end
            if (st.oVALID && st.iREADY) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got beat %0d with 0x%0h, expected no beat", frame_beats, st.oDATA);
                end else begin
                    check("beat", 64'({st.oLAST, st.oDATA}), 64'(exp_q.pop_front()));
                end
                frame_beats++;
            end
            if (oDONE) done_cnt++;
            stall_prev = st.oVALID && !st.iREADY;
            prev_out = {st.oLAST, st.oDATA};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_first_latency(input string name);
        int k = 0;
        @(negedge iCLK); #1;
        while (!st.oVALID && k < 50) begin
            @(negedge iCLK); #1;
            k++;
        end
        check({name, "_first_valid_cycles"}, 64'(k), 64'(FIRST_LAT));
    endtask

    task automatic start_frame(input string name);
        @(posedge iCLK); #1 iRDY = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        frame_beats = 0;
        done_cnt = 0;
        iRDY = 1'b1;
        check_first_latency(name);
    endtask

    task automatic wait_beats(input int target, input string name);
        int cyc = 0;
        while (frame_beats < target && cyc < BUDGET) begin
            @(negedge iCLK); #1;
            cyc++;
        end
        check({name, "_reached_beats"}, 64'(frame_beats >= target), 64'd1);
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!oDONE && cyc < BUDGET) begin
            @(negedge iCLK); #1;
            cyc++;
        end
        check({name, "_done_seen"}, 64'(oDONE), 64'd1);
        repeat (8) begin
            @(negedge iCLK); #1;
        end
        check({name, "_beats"}, 64'(frame_beats), 64'(N));
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_after"}, 64'(oBUSY), 64'd0);
        check({name, "_valid_after"}, 64'(st.oVALID), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        iRESET = 1'b0;
        iRDY = 1'b1;
        fill_ramp();
        repeat (3) @(negedge iCLK);
        #1;
        check("rst_addr", 64'(oADDR_RD), 64'd0);
        check("rst_data", 64'(st.oDATA), 64'd0);
        check("rst_valid", 64'(st.oVALID), 64'd0);
        check("rst_last", 64'(st.oLAST), 64'd0);
        check("rst_busy", 64'(oBUSY), 64'd0);
        check("rst_done", 64'(oDONE), 64'd0);

        // Ramp frame, started by the 0->1 edge seen right after reset release.
        load_expected();
        check("model_ramp_first", 64'(exp_q[0]), 64'd0);
`ifdef FHT_RD_SQR_EN
        check("model_ramp_last", 64'(exp_q[N-1]), 64'({1'b1, 32'd1046529}));
`else
        check("model_ramp_last", 64'(exp_q[N-1]), 64'({1'b1, 32'd1023}));
`endif
        ready_pct = 100;
        @(posedge iCLK); #1;
        frame_beats = 0;
        done_cnt = 0;
        iRESET = 1'b1;
        check_first_latency("ramp");
        wait_done("ramp");

        // Random data with heavy backpressure.
        fill_random();
        load_expected();
        ready_pct = 30;
        start_frame("bp");
        wait_done("bp");

        // Spurious iRDY toggle while reading.
        fill_random();
        load_expected();
        ready_pct = 70;
        start_frame("spur");
        wait_beats(100, "spur");
        @(posedge iCLK); #1 iRDY = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 iRDY = 1'b1;
        check("spur_busy", 64'(oBUSY), 64'd1);
        wait_done("spur");

        // Signed word at sample 0.
        fill_ramp();
        mem[0][0] = 16'hFFFB;
        load_expected();
`ifdef FHT_RD_SQR_EN
        check("model_signed", 64'(exp_q[0]), 64'({1'b0, 32'd25}));
`else
        check("model_signed", 64'(exp_q[0]), 64'({1'b0, 32'hFFFFFFFB}));
`endif
        ready_pct = 100;
        start_frame("signed");
        wait_done("signed");

        // Abort with reset at beat 300, then a clean full frame.
        fill_random();
        load_expected();
        ready_pct = 100;
        start_frame("abort");
        wait_beats(300, "abort");
        @(posedge iCLK); #1;
        iRESET = 1'b0;
        iRDY = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK); #1;
        check("abort_valid", 64'(st.oVALID), 64'd0);
        check("abort_busy", 64'(oBUSY), 64'd0);
        check("abort_done", 64'(done_cnt), 64'd0);
        @(posedge iCLK); #1 iRESET = 1'b1;
        repeat (5) begin
            @(negedge iCLK); #1;
            check("abort_idle_busy", 64'(oBUSY), 64'd0);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        load_expected();
        start_frame("restart");
        wait_done("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
